// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: walks a runtime-loaded table of I2C commands and
// presents each one to the I2C master core. Each command waits for the
// core's completion, is re-issued after a NACK up to RETRY_MAX times and is
// failed if the core does not complete within TIMEOUT_CYC cycles. Bytes from
// read modes (0x04..0x06) are captured into a result buffer.
// Build option: define I2C_RD_VERIFY_EN to fail a read whose returned byte
// differs from the entry's data field (err_code 2).
module i2c_cmd_sequencer #(
   parameter int DEPTH       = 8,
   parameter int IDX_W       = 3,
   parameter int RETRY_MAX   = 3,
   parameter int TIMEOUT_CYC = 120000,
   parameter int GAP_CYC     = 16
) (
   input  logic             clk_12m,
   input  logic             rst_n,
   input  logic             start,
   input  logic             tbl_we,
   input  logic [IDX_W-1:0] tbl_addr,
   input  logic [30:0]      tbl_wdata,
   input  logic             i2c_done,
   input  logic             i2c_nack,
   input  logic [7:0]       i2c_read_data,
   output logic [7:0]       i2c_config,
   output logic [6:0]       i2c_dev_addr,
   output logic [7:0]       i2c_reg_addr,
   output logic [7:0]       i2c_reg_data,
   input  logic [IDX_W-1:0] res_addr,
   output logic [7:0]       res_data,
   output logic             busy,
   output logic             seq_done,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [IDX_W-1:0] cur_idx
);

   localparam int TMO_W = $clog2(TIMEOUT_CYC);
   localparam int GAP_W = $clog2(GAP_CYC);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_CHECK, S_GAP, S_FINISH, S_FAIL
   } state_t;

   state_t           r_state;
   logic [30:0]      r_tbl [DEPTH];
   logic [7:0]       r_res [DEPTH];
   logic [30:0]      r_entry;
   logic [IDX_W-1:0] r_idx;
   logic [3:0]       r_retry;
   logic [TMO_W-1:0] r_tmo;
   logic [GAP_W-1:0] r_gap;
   logic             r_reissue;
   logic [7:0]       r_config;
   logic [6:0]       r_dev;
   logic [7:0]       r_reg;
   logic [7:0]       r_wdata;
   logic [7:0]       r_res_data;
   logic             r_busy;
   logic             r_seq_done;
   logic             r_err;
   logic [1:0]       r_err_code;
   logic             r_done_s1, r_done_s2, r_done_s3, r_done_p;
   logic             r_nack;
   logic [7:0]       r_rdata;

   logic w_done_rise;
   logic w_is_read;
   logic w_res_we;

   assign w_done_rise = r_done_s2 & ~r_done_s3;
   assign w_is_read   = (r_entry[30:23] == 8'h04) || (r_entry[30:23] == 8'h05) ||
                        (r_entry[30:23] == 8'h06);
   assign w_res_we    = (r_state == S_CHECK) && w_is_read;

   assign i2c_config   = r_config;
   assign i2c_dev_addr = r_dev;
   assign i2c_reg_addr = r_reg;
   assign i2c_reg_data = r_wdata;
   assign res_data     = r_res_data;
   assign busy         = r_busy;
   assign seq_done     = r_seq_done;
   assign err          = r_err;
   assign err_code     = r_err_code;
   assign cur_idx      = r_idx;

   // Synchronise i2c_done, detect its rising edge, and capture nack/data with that pulse.
   // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
   always_ff @(posedge clk_12m or negedge rst_n) begin
      if (!rst_n) begin
         r_done_s1 <= 1'b0;
         r_done_s2 <= 1'b0;
         r_done_s3 <= 1'b0;
         r_done_p  <= 1'b0;
         r_nack    <= 1'b0;
         r_rdata   <= 8'h00;
      end else begin
         r_done_s1 <= i2c_done;
         r_done_s2 <= r_done_s1;
         r_done_s3 <= r_done_s2;
         r_done_p  <= w_done_rise;
         if (w_done_rise) begin
            r_nack  <= i2c_nack;
            r_rdata <= i2c_read_data;
         end
      end
   end

   // Command table write port; writes are dropped while a sequence runs.
   // NOTE: storage arrays carry no reset so they map onto plain RAM; only control state is reset.
   always_ff @(posedge clk_12m) begin
      if (tbl_we && !r_busy) r_tbl[tbl_addr] <= tbl_wdata;
   end

   // Result buffer write port, fed by read-mode completions.
   always_ff @(posedge clk_12m) begin
      if (w_res_we) r_res[r_idx] <= r_rdata;
   end

   // Registered result read; a same-cycle write to the same index is seen next cycle.
   always_ff @(posedge clk_12m or negedge rst_n) begin
      if (!rst_n) r_res_data <= 8'h00;
      else        r_res_data <= r_res[res_addr];
   end

   // Sequencer FSM with registered core-facing and status outputs.
   always_ff @(posedge clk_12m or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_entry    <= '0;
         r_idx      <= '0;
         r_retry    <= '0;
         r_tmo      <= '0;
         r_gap      <= '0;
         r_reissue  <= 1'b0;
         r_config   <= 8'h00;
         r_dev      <= 7'h00;
         r_reg      <= 8'h00;
         r_wdata    <= 8'h00;
         r_busy     <= 1'b0;
         r_seq_done <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= 2'd0;
      end else begin
         r_seq_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_idx      <= '0;
                  r_retry    <= '0;
                  r_reissue  <= 1'b0;
                  r_busy     <= 1'b1;
                  r_err      <= 1'b0;
                  r_err_code <= 2'd0;
                  r_state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_entry <= r_tbl[r_idx];
               if (r_tbl[r_idx][30:23] == 8'h00) begin
                  r_busy     <= 1'b0;
                  r_seq_done <= 1'b1;
                  r_state    <= S_FINISH;
               end else begin
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_config <= r_entry[30:23];
               r_dev    <= r_entry[22:16];
               r_reg    <= r_entry[15:8];
               r_wdata  <= r_entry[7:0];
               r_tmo    <= '0;
               r_state  <= S_WAIT;
            end
            S_WAIT: begin
               r_tmo <= r_tmo + 1'b1;
               if (r_done_p) begin
                  if (!r_nack) begin
                     r_state <= S_CHECK;
                  end else if (r_retry < 4'(RETRY_MAX)) begin
                     r_retry   <= r_retry + 1'b1;
                     r_reissue <= 1'b1;
                     r_config  <= 8'h00;
                     r_gap     <= '0;
                     r_state   <= S_GAP;
                  end else begin
                     r_err      <= 1'b1;
                     r_err_code <= 2'd1;
                     r_config   <= 8'h00;
                     r_busy     <= 1'b0;
                     r_state    <= S_FAIL;
                  end
               end else if (r_tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
                  r_err      <= 1'b1;
                  r_err_code <= 2'd3;
                  r_config   <= 8'h00;
                  r_busy     <= 1'b0;
                  r_state    <= S_FAIL;
               end
            end
            S_CHECK: begin
`ifdef I2C_RD_VERIFY_EN
               if (w_is_read && (r_rdata != r_entry[7:0])) begin
                  r_err      <= 1'b1;
                  r_err_code <= 2'd2;
                  r_config   <= 8'h00;
                  r_busy     <= 1'b0;
                  r_state    <= S_FAIL;
               end else begin
                  r_retry   <= '0;
                  r_reissue <= 1'b0;
                  r_idx     <= r_idx + 1'b1;
                  r_config  <= 8'h00;
                  r_gap     <= '0;
                  r_state   <= S_GAP;
               end
`else
               r_retry   <= '0;
               r_reissue <= 1'b0;
               r_idx     <= r_idx + 1'b1;
               r_config  <= 8'h00;
               r_gap     <= '0;
               r_state   <= S_GAP;
`endif
            end
            S_GAP: begin
               r_gap <= r_gap + 1'b1;
               if (r_gap == GAP_W'(GAP_CYC - 1)) begin
                  if (r_reissue) begin
                     r_state <= S_ISSUE;
                  end else if (r_idx == '0) begin
                     // Index wrapped: every table entry has been executed.
                     r_busy     <= 1'b0;
                     r_seq_done <= 1'b1;
                     r_state    <= S_FINISH;
                  end else begin
                     r_state <= S_LOAD;
                  end
               end
            end
            S_FINISH: r_state <= S_IDLE;
            S_FAIL:   r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

endmodule
